cla_pipe_adder: RTL and testbench
=================================

// Module: cla_pipe_adder
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 32-bit CLA.
//  Operand word split into STAGES equal segments; each pipeline stage adds one segment with
//  GROUP-bit lookahead blocks; inter-segment carry registered. Valid/ready stream handshake on
//  both sides; sits between operand source and result consumer in the datapath.
// PARAMETERS
//  WIDTH   32  operand/result width; WIDTH % (STAGES*GROUP) == 0 (elaboration error otherwise)
//  GROUP    4  bits per lookahead block (generate/propagate group)
//  STAGES   2  pipeline stages = segments = latency in cycles; 1..8
// PORTS
//  Clk        in   1      clock, all logic on rising edge
//  Rst        in   1      synchronous reset, active-high
//  In_Valid   in   1      A/B/Cin/Sub valid this cycle
//  In_Ready   out  1      block accepts input this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  Cin        in   1      carry-in (ignored when Sub=1)
//  Sub        in   1      1: S = A + ~B + 1; 0: S = A + B + Cin
//  Out_Valid  out  1      S/Cout (/Ovf) valid
//  Out_Ready  in   1      consumer accepts result
//  S          out  WIDTH  sum/difference, modulo 2^WIDTH
//  Cout       out  1      carry out of MSB (Sub: 1 = no borrow)
//  Ovf        out  1      signed overflow (only with CLA_SIGNED_OVF_EN)
// BEHAVIOUR
//  - Reset: all stage valid bits 0; Out_Valid=0, S=0, Cout=0, Ovf=0; In_Ready=1 next cycle.
//  - Accept: In_Valid && In_Ready at rising edge. Fire: Out_Valid && Out_Ready.
//  - Global stall: adv = !Out_Valid || Out_Ready; In_Ready = adv (combinational from Out_Ready).
//    adv=1: every stage register shifts one step; adv=0: all stages hold, S/Cout/Ovf stable.
//  - Bubbles are not compressed; an empty stage still advances only when adv=1.
//  - Latency: accepted word appears on Out_Valid exactly STAGES cycles later with no stalls;
//    throughput 1 word/cycle; results strictly in acceptance order; no loss, no duplication.
//  - Stage k (0..STAGES-1) computes segment bits [(k+1)*W/STAGES-1 : k*W/STAGES] using carry
//    registered from stage k-1 (stage 0 uses Cin, or 1 when Sub); upper-segment operands and
//    completed lower-segment sum bits ride forward in delay registers.
//  - Sub: B inverted at stage 0 entry; inversion and forced carry captured with the word.
//  - Within a segment: GROUP-bit lookahead blocks, block-level carry lookahead across blocks
//    (no ripple between groups). STAGES=1: purely combinational adder into one output register.
//  - Cout = carry out of bit WIDTH-1 of final segment; A=B=all-ones, Cin=1 -> S=all-ones, Cout=1.
//  - Rst asserted mid-operation: all in-flight words discarded, Out_Valid=0 next cycle, no
//    partial result ever presented. Rst has priority over accept.
//  - In_Valid with In_Ready=0: input ignored; source must hold (not checked).
// CONFIGURATION
//  CLA_SIGNED_OVF_EN defined: Ovf port present; Ovf = carry into MSB XOR carry out of MSB of the
//    effective addition (inverted B for Sub), registered alongside S; reset 0.
//  Not defined: Ovf port absent, no overflow logic; all other behaviour identical.
// TESTING (WIDTH=32, GROUP=4, STAGES=2 unless noted; Out_Ready=1 unless noted)
//  1 A=FFFF0000 B=0000FFFF Cin=1 Sub=0 -> 2 cycles later S=00000000 Cout=1
//  2 Back-to-back: (2017701177,1701853,Cin=0) then (FFABCEDC,EF821EDA,Cin=1) -> consecutive
//    cycles S=2019403030 Cout=0, then S=EF2DEDB7 Cout=1
//  3 Sub=1 A=5 B=7 -> S=FFFFFFFE Cout=0; A=7 B=5 -> S=00000002 Cout=1
//  4 CLA_SIGNED_OVF_EN: 7FFFFFFF+00000001 -> S=80000000 Ovf=1 Cout=0; 80000000-1 (Sub) -> Ovf=1
//  5 3 words back-to-back, Out_Ready=0 for 4 cycles once Out_Valid=1 -> In_Ready=0, S stable;
//    release -> 3 results in order, one per cycle, none lost/duplicated
//  6 Rst pulse with 2 words in flight -> Out_Valid=0 next cycle, S=0, no stale result later;
//    repeat tests 1-2 with STAGES=1 (latency 1) and STAGES=4, WIDTH=64

Source files
------------

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder
//   Pipelined carry-lookahead adder/subtractor. The operand word is cut into
//   STAGES equal segments; pipeline stage k adds segment k using GROUP-bit
//   lookahead blocks with block-level lookahead across the segment. The carry
//   out of each segment is registered and feeds the next stage. Upper operand
//   bits and completed lower sum bits ride forward in delay registers.
//   A single global stall (adv) freezes the whole pipe when the consumer is
//   not taking a presented result. Bubbles are not compressed.
//
// Parameters
//   WIDTH   operand/result width, WIDTH % (STAGES*GROUP) == 0
//   GROUP   bits per lookahead block
//   STAGES  pipeline stages = segments = latency (1..8)
//
// Ports
//   Clk        clock, rising edge
//   Rst        synchronous reset, active high
//   In_Valid   A/B/Cin/Sub valid
//   In_Ready   block accepts input this cycle (combinational from Out_Ready)
//   A, B       operands
//   Cin        carry-in, ignored when Sub=1
//   Sub        1: S = A + ~B + 1, 0: S = A + B + Cin
//   Out_Valid  S/Cout(/Ovf) valid
//   Out_Ready  consumer accepts result
//   S          sum/difference mod 2^WIDTH
//   Cout       carry out of MSB (subtract: 1 = no borrow)
//   Ovf        signed overflow, present only when CLA_SIGNED_OVF_EN is defined
//
// Build option
//   CLA_SIGNED_OVF_EN : adds the Ovf port and its register.

module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef CLA_SIGNED_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / GROUP;

    if ((STAGES < 1) || (STAGES > 8) || ((WIDTH % (STAGES * GROUP)) != 0)) begin : g_bad_cfg
        $error("cla_pipe_adder: need 1<=STAGES<=8 and WIDTH %% (STAGES*GROUP) == 0");
    end

    // One segment add: returns {carry_out, sum}.
    // Group G/P are formed per GROUP-bit block; every block carry and every bit
    // carry is an independent sum-of-products of G/P terms and the segment
    // carry-in, so no carry ripples from one group into the next.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           ci);
        logic [SEG-1:0]  g;
        logic [SEG-1:0]  p;
        logic [SEG-1:0]  c;
        logic [NGRP-1:0] bg;
        logic [NGRP-1:0] bp;
        logic [NGRP:0]   bc;
        logic            t;
        g  = a & b;
        p  = a ^ b;
        c  = '0;
        bg = '0;
        bp = '1;
        bc = '0;
        for (int j = 0; j < NGRP; j++) begin
            for (int i = 0; i < GROUP; i++) begin
                bg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & bg[j]);
                bp[j] = bp[j] & p[j*GROUP+i];
            end
        end
        bc[0] = ci;
        for (int j = 0; j < NGRP; j++) begin
            t = ci;
            for (int n = 0; n <= j; n++) t = t & bp[n];
            bc[j+1] = t;
            for (int m = 0; m <= j; m++) begin
                t = bg[m];
                for (int n = m + 1; n <= j; n++) t = t & bp[n];
                bc[j+1] = bc[j+1] | t;
            end
        end
        for (int j = 0; j < NGRP; j++) begin
            for (int i = 0; i < GROUP; i++) begin
                t = bc[j];
                for (int n = 0; n < i; n++) t = t & p[j*GROUP+n];
                c[j*GROUP+i] = t;
                for (int m = 0; m < i; m++) begin
                    t = g[j*GROUP+m];
                    for (int n = m + 1; n < i; n++) t = t & p[j*GROUP+n];
                    c[j*GROUP+i] = c[j*GROUP+i] | t;
                end
            end
        end
        return {bc[NGRP], p ^ c};
    endfunction

    logic              w_adv;
    logic [STAGES:0]   w_vld_pipe;
    logic [STAGES-1:0] r_vld_pipe;   // bit k: word in register after stage k

    // Stage inputs (w_*) and the register bank after each stage (r_*).
    logic [WIDTH-1:0]  w_a   [STAGES];
    logic [WIDTH-1:0]  w_b   [STAGES];   // already inverted for subtract
    logic [WIDTH-1:0]  w_sp  [STAGES];   // lower segments finished so far
    logic              w_c   [STAGES];
    logic [SEG:0]      w_res [STAGES];
    logic [WIDTH-1:0]  w_sn  [STAGES];
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_s   [STAGES];
    logic              r_c   [STAGES];

    assign Out_Valid  = w_vld_pipe[STAGES];
    assign w_adv      = !Out_Valid || Out_Ready;
    assign In_Ready   = w_adv;
    assign w_vld_pipe = {r_vld_pipe, In_Valid};

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * SEG;
        localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}}) << LO;

        if (k == 0) begin : g_src
            // Inversion and forced carry are captured with the word here.
            assign w_a[k]  = A;
            assign w_b[k]  = Sub ? ~B : B;
            assign w_sp[k] = '0;
            assign w_c[k]  = Sub | Cin;
        end else begin : g_src
            assign w_a[k]  = r_a[k-1];
            assign w_b[k]  = r_b[k-1];
            assign w_sp[k] = r_s[k-1];
            assign w_c[k]  = r_c[k-1];
        end

        assign w_res[k] = seg_add(w_a[k][LO +: SEG], w_b[k][LO +: SEG], w_c[k]);
        assign w_sn[k]  = (w_sp[k] & ~SEG_MASK) | (WIDTH'(w_res[k][SEG-1:0]) << LO);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_vld_pipe <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end
        end else if (w_adv) begin
            r_vld_pipe <= w_vld_pipe[STAGES-1:0];
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= w_a[k];
                r_b[k] <= w_b[k];
                r_s[k] <= w_sn[k];
                r_c[k] <= w_res[k][SEG];
            end
        end
    end

    assign S    = r_s[STAGES-1];
    assign Cout = r_c[STAGES-1];

`ifdef CLA_SIGNED_OVF_EN
    // Carry into the MSB is recovered as a^b^sum at that bit.
    logic w_ovf;
    logic r_ovf;
    assign w_ovf = w_a[STAGES-1][WIDTH-1] ^ w_b[STAGES-1][WIDTH-1]
                 ^ w_res[STAGES-1][SEG-1] ^ w_res[STAGES-1][SEG];

    always_ff @(posedge Clk) begin
        if (Rst)        r_ovf <= 1'b0;
        else if (w_adv) r_ovf <= w_ovf;
    end
    assign Ovf = r_ovf;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        ordy0 = 1'b1;
    int          rdy_mode = 0;     // 0: ready, 1: stalled, 2: random
    int          stall_seen = 0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    logic        ir0, ov0, c0, ir1, ov1, c1, ir2, ov2, c2;
    logic [31:0] s0, s1;
    logic [63:0] s2;
`ifdef CLA_SIGNED_OVF_EN
    logic        o0, o1, o2;
`endif

    exp_t exp32, exp64, e0, e1, e2;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(2)) u0 (
        .Clk(clk), .Rst(rst), .In_Valid(in_valid), .In_Ready(ir0),
        .A(a[31:0]), .B(b[31:0]), .Cin(cin), .Sub(sub),
        .Out_Valid(ov0), .Out_Ready(ordy0), .S(s0), .Cout(c0)
`ifdef CLA_SIGNED_OVF_EN
        , .Ovf(o0)
`endif
    );

    cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(1)) u1 (
        .Clk(clk), .Rst(rst), .In_Valid(in_valid), .In_Ready(ir1),
        .A(a[31:0]), .B(b[31:0]), .Cin(cin), .Sub(sub),
        .Out_Valid(ov1), .Out_Ready(1'b1), .S(s1), .Cout(c1)
`ifdef CLA_SIGNED_OVF_EN
        , .Ovf(o1)
`endif
    );

    cla_pipe_adder #(.WIDTH(64), .GROUP(4), .STAGES(4)) u2 (
        .Clk(clk), .Rst(rst), .In_Valid(in_valid), .In_Ready(ir2),
        .A(a), .B(b), .Cin(cin), .Sub(sub),
        .Out_Valid(ov2), .Out_Ready(1'b1), .S(s2), .Cout(c2)
`ifdef CLA_SIGNED_OVF_EN
        , .Ovf(o2)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       ordy0 = 1'b1;
            1:       ordy0 = 1'b0;
            default: ordy0 = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Plain wide-integer reference for a w-bit add/subtract.
    function automatic exp_t model(input int w, input logic [63:0] ia, input logic [63:0] ib,
                                   input logic icin, input logic isub);
        exp_t        r;
        logic [63:0] m;
        logic [63:0] aa;
        logic [63:0] bb;
        logic [64:0] full;
        m    = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        aa   = ia & m;
        bb   = (isub ? ~ib : ib) & m;
        full = {1'b0, aa} + {1'b0, bb} + {64'd0, (isub | icin)};
        r.s  = full[63:0] & m;
        r.c  = full[w];
        r.o  = (aa[w-1] == bb[w-1]) && (r.s[w-1] != aa[w-1]);
        r.t  = 0;
        return r;
    endfunction

    // Scoreboard: push on accept, pop and compare on fire.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            if (ov0 && ordy0) begin
                if (q0.size() == 0) chk("u0_unexpected_out", 64'd1, 64'd0);
                else begin
                    e0 = q0.pop_front();
                    chk("u0_s", {32'd0, s0}, e0.s);
                    chk("u0_cout", {63'd0, c0}, {63'd0, e0.c});
`ifdef CLA_SIGNED_OVF_EN
                    chk("u0_ovf", {63'd0, o0}, {63'd0, e0.o});
`endif
                    if (stall_seen == 0) chk("u0_latency", 64'(cyc - e0.t), 64'd2);
                end
            end
            if (ov1) begin
                if (q1.size() == 0) chk("u1_unexpected_out", 64'd1, 64'd0);
                else begin
                    e1 = q1.pop_front();
                    chk("u1_s", {32'd0, s1}, e1.s);
                    chk("u1_cout", {63'd0, c1}, {63'd0, e1.c});
`ifdef CLA_SIGNED_OVF_EN
                    chk("u1_ovf", {63'd0, o1}, {63'd0, e1.o});
`endif
                    chk("u1_latency", 64'(cyc - e1.t), 64'd1);
                end
            end
            if (ov2) begin
                if (q2.size() == 0) chk("u2_unexpected_out", 64'd1, 64'd0);
                else begin
                    e2 = q2.pop_front();
                    chk("u2_s", s2, e2.s);
                    chk("u2_cout", {63'd0, c2}, {63'd0, e2.c});
`ifdef CLA_SIGNED_OVF_EN
                    chk("u2_ovf", {63'd0, o2}, {63'd0, e2.o});
`endif
                    chk("u2_latency", 64'(cyc - e2.t), 64'd4);
                end
            end
            if (in_valid && ir0) begin e0 = exp32; e0.t = cyc; q0.push_back(e0); end
            if (in_valid && ir1) begin e1 = exp32; e1.t = cyc; q1.push_back(e1); end
            if (in_valid && ir2) begin e2 = exp64; e2.t = cyc; q2.push_back(e2); end
        end
    end

    // Present a word; constants override the 32-bit expectation when use_k=1.
    task automatic put(input logic [63:0] ia, input logic [63:0] ib, input logic icin,
                       input logic isub, input logic use_k, input logic [31:0] ks,
                       input logic kc);
        in_valid = 1'b1;
        a = ia; b = ib; cin = icin; sub = isub;
        exp32 = model(32, ia, ib, icin, isub);
        if (use_k) begin
            exp32.s = {32'd0, ks};
            exp32.c = kc;
        end
        exp64 = model(64, ia, ib, icin, isub);
    endtask

    task automatic wait_acc();
        int n;
        n = 0;
        @(negedge clk);
        while (!ir0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!ir0) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [63:0] ia, input logic [63:0] ib, input logic icin,
                        input logic isub, input logic use_k, input logic [31:0] ks,
                        input logic kc);
        put(ia, ib, icin, isub, use_k, ks, kc);
        wait_acc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, ov0}, 64'd0);
        chk("rst_s", {32'd0, s0}, 64'd0);
        chk("rst_cout", {63'd0, c0}, 64'd0);
        chk("rst_in_ready", {63'd0, ir0}, 64'd1);
        chk("rst_u2_s", s2, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic vectors, back-to-back, with fixed expected values.
        send(64'hFFFF0000, 64'h0000FFFF, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b1);
        send(64'd2017701177, 64'd1701853, 1'b0, 1'b0, 1'b1, 32'd2019403030, 1'b0);
        send(64'hFFABCEDC, 64'hEF821EDA, 1'b1, 1'b0, 1'b1, 32'hEF2DEDB7, 1'b1);
        send(64'd5, 64'd7, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0);
        send(64'd7, 64'd5, 1'b1, 1'b1, 1'b1, 32'h00000002, 1'b1);
        send(64'h7FFFFFFF, 64'h00000001, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b0);
        send(64'h80000000, 64'h00000001, 1'b0, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1,
             32'hFFFFFFFF, 1'b1);
        repeat (6) @(posedge clk);
        #1;

        // Output stall: two words in the pipe, third held at the input.
        stall_seen = 1;
        rdy_mode   = 1;
        send(64'h12345678, 64'h11111111, 1'b0, 1'b0, 1'b1, 32'h23456789, 1'b0);
        send(64'h80000000, 64'h80000000, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b1);
        put(64'h00000000, 64'h00000001, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, ir0}, 64'd0);
            chk("stall_out_valid", {63'd0, ov0}, 64'd1);
            chk("stall_s_hold", {32'd0, s0}, 64'h23456789);
        end
        rdy_mode = 0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("release_out_valid", {63'd0, ov0}, 64'd1);
            if (i == 0) begin
                chk("release_in_ready", {63'd0, ir0}, 64'd1);
                @(posedge clk);
                #1 in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("release_no_dup", {63'd0, ov0}, 64'd0);

        // Reset with two words in flight and a word offered during reset.
        @(posedge clk);
        #1;
        send(64'hDEADBEEF_01234567, 64'h0F0F0F0F_89ABCDEF, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        send(64'h00000000_FFFFFFFF, 64'h00000001_00000001, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        put(64'h1, 64'h1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("flush_out_valid", {63'd0, ov0}, 64'd0);
        chk("flush_s", {32'd0, s0}, 64'd0);
        chk("flush_u1_valid", {63'd0, ov1}, 64'd0);
        chk("flush_u2_valid", {63'd0, ov2}, 64'd0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        in_valid   = 1'b0;
        stall_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flush_no_stale", {63'd0, ov0 | ov1 | ov2}, 64'd0);
        end
        @(posedge clk);
        #1;

        // Post-reset sanity, then random words with random back-pressure.
        send(64'hFFFF0000, 64'h0000FFFF, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b1);
        stall_seen = 1;
        rdy_mode   = 2;
        for (int i = 0; i < 40; i++) begin
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, 32'd0, 1'b0);
        end
        rdy_mode = 0;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
